// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the cache-port front end: default cache transaction
//   ID / tag widths, well-known channel indices, the request direction
//   encoding and an index-width helper.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Default cache transaction ID width (2**MEM_ID_SIZE IDs tracked).
  localparam int MEM_ID_SIZE  = 4;
  // Default channel-local tag width, echoed back on the response.
  localparam int MEM_TAG_SIZE = 4;

  // Conventional channel assignment: instruction fetch first, so that a
  // fixed-priority build never starves fetch.
  localparam int CH_IF  = 0;
  localparam int CH_LSU = 1;

  // Encoding of the per-channel req_rw bit.
  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  // Width of an index into n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_rr
//   Round-robin arbiter. Searches the request mask starting at the pointer
//   and wrapping, returns a one-hot grant plus its index. When advance is
//   high the pointer moves to (granted + 1) mod NUM_CH, otherwise it holds.
//
// Ports
//   clk        in  clock
//   reset      in  asynchronous active-low reset (pointer -> 0)
//   req        in  NUM_CH request mask
//   advance    in  the current grant was consumed this cycle
//   grant      out NUM_CH one-hot grant (all zero when req is zero)
//   grant_idx  out index of the granted channel
// -----------------------------------------------------------------------------
module mem_port_arbiter_rr
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr;

  // Walk from the farthest candidate back to the pointer; the last hit, i.e.
  // the one closest to the pointer, overwrites the others.
  // NOTE: every output of a combinational block is given a default at the
  // top, so no path through the block leaves a value unassigned and no latch
  // is inferred.
  always_comb begin
    int c;
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (req[c]) begin
        grant            = '0;
        grant[c]         = 1'b1;
        grant_idx        = CH_W'(c);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Cache-port front end. NUM_CH requesters share one tagged cache port.
//   One request is accepted per cycle when the issue slot is free; reads also
//   need a free transaction ID (lowest free ID is allocated), writes need
//   none and issue with ID 0. The ID table remembers {channel, tag} for each
//   outstanding read so the cache response can be routed back.
//
//   Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (channel 0
//   highest, no round-robin pointer). Default build is round robin.
//
// Ports
//   clk, reset                        clock, asynchronous active-low reset
//   req_valid/rw/addr/data/tag        per-channel request, packed by channel
//   req_accept                        one-hot, request consumed this cycle
//   mem_valid/addr/data/rw/id_out     registered request to the cache
//   mem_stall_in                      cache cannot take the request; hold
//   mem_data_in/id_in/ready_in        cache response for a read ID
//   rsp_valid                         one-hot registered response strobe
//   rsp_data, rsp_tag                 response data and local tag (shared)
//   outstanding                       number of IDs in use
//   spurious_err                      sticky: response for an unallocated ID
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = MEM_ID_SIZE,
  parameter int TAG_W  = MEM_TAG_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_rw,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  input  logic [NUM_CH*TAG_W-1:0]  req_tag,
  output logic [NUM_CH-1:0]        req_accept,
  output logic [ADDR_W-1:0]        mem_addr_out,
  output logic [DATA_W-1:0]        mem_data_out,
  output logic                     mem_rw_out,
  output logic [ID_W-1:0]          mem_id_out,
  output logic                     mem_valid_out,
  input  logic                     mem_stall_in,
  input  logic [DATA_W-1:0]        mem_data_in,
  input  logic [ID_W-1:0]          mem_id_in,
  input  logic                     mem_ready_in,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [ID_W:0]            outstanding,
  output logic                     spurious_err
);

  localparam int NUM_IDS = 1 << ID_W;
  localparam int CH_W    = idx_w(NUM_CH);

  logic [NUM_IDS-1:0] free_mask;
  logic [NUM_IDS-1:0] free_nxt;
  logic [CH_W-1:0]    tbl_ch  [NUM_IDS];
  logic [TAG_W-1:0]   tbl_tag [NUM_IDS];

  logic               slot_free;
  logic               id_avail;
  logic [ID_W-1:0]    free_id;
  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  grant;
  logic [CH_W-1:0]    grant_idx;
  logic               accept;
  logic               alloc;
  logic               rsp_hit;
  logic               rsp_bogus;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_rw;

  assign slot_free = !mem_valid_out || !mem_stall_in;
  assign id_avail  = |free_mask;

  // Lowest-numbered free ID.
  always_comb begin
    free_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (free_mask[i]) free_id = ID_W'(i);
    end
  end

  // A read without a free ID is invisible to the arbiter, so a write from
  // another channel can still win the cycle.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c] = req_valid[c] && (req_rw[c] || id_avail);
    end
  end

  // Gated by reset so nothing is reported as consumed while held in reset.
  assign accept = reset && slot_free && (|eligible);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Channel 0 highest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (eligible[c]) begin
        grant     = '0;
        grant[c]  = 1'b1;
        grant_idx = CH_W'(c);
      end
    end
  end
`else
  mem_port_arbiter_rr #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
`endif

  assign req_accept = accept ? grant : '0;

  // Granted channel's request fields.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_tag  = '0;
    sel_rw   = RW_READ;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == CH_W'(c)) begin
        sel_addr = req_addr[c*ADDR_W +: ADDR_W];
        sel_data = req_data[c*DATA_W +: DATA_W];
        sel_tag  = req_tag[c*TAG_W +: TAG_W];
        sel_rw   = req_rw[c];
      end
    end
  end

  assign alloc     = accept && (sel_rw == RW_READ);
  assign rsp_hit   = mem_ready_in && !free_mask[mem_id_in];
  assign rsp_bogus = mem_ready_in &&  free_mask[mem_id_in];

  // The allocated ID is never the returning one (it was free), so both
  // updates can apply in the same cycle. A returned ID becomes allocatable
  // only after this edge.
  always_comb begin
    free_nxt = free_mask;
    if (alloc)   free_nxt[free_id]   = 1'b0;
    if (rsp_hit) free_nxt[mem_id_in] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_out <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      mem_rw_out    <= 1'b0;
      mem_id_out    <= '0;
      free_mask     <= '1;
      outstanding   <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_tag       <= '0;
      spurious_err  <= 1'b0;
      // NOTE: the ID table is small and is cleared on reset so its contents
      // are defined after reset; a large RAM would instead rely on the free
      // mask alone and skip the reset.
      for (int i = 0; i < NUM_IDS; i++) begin
        tbl_ch[i]  <= '0;
        tbl_tag[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_valid_out <= 1'b1;
        mem_addr_out  <= sel_addr;
        mem_data_out  <= sel_data;
        mem_rw_out    <= sel_rw;
        mem_id_out    <= alloc ? free_id : '0;
      end else if (slot_free) begin
        mem_valid_out <= 1'b0;
      end

      if (alloc) begin
        tbl_ch[free_id]  <= grant_idx;
        tbl_tag[free_id] <= sel_tag;
      end

      free_mask   <= free_nxt;
      outstanding <= outstanding + (ID_W+1)'(alloc) - (ID_W+1)'(rsp_hit);

      rsp_valid <= rsp_hit ? (NUM_CH'(1) << tbl_ch[mem_id_in]) : '0;
      if (rsp_hit) begin
        rsp_data <= mem_data_in;
        rsp_tag  <= tbl_tag[mem_id_in];
      end

      if (rsp_bogus) spurious_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (NUM_CH=2, 16 IDs, 4-bit tags).
//   Inputs change 1 time unit after the rising edge; combinational outputs
//   are compared 1 unit later, registered outputs 1 unit after the edge.
//   Request k of channel c uses address 0x1000*(c+1)+4k and tag 8c+k.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int TAG_W  = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_rw;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH*TAG_W-1:0]  req_tag;
  logic [NUM_CH-1:0]        req_accept;
  logic [ADDR_W-1:0]        mem_addr_out;
  logic [DATA_W-1:0]        mem_data_out;
  logic                     mem_rw_out;
  logic [ID_W-1:0]          mem_id_out;
  logic                     mem_valid_out;
  logic                     mem_stall_in;
  logic [DATA_W-1:0]        mem_data_in;
  logic [ID_W-1:0]          mem_id_in;
  logic                     mem_ready_in;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic [TAG_W-1:0]         rsp_tag;
  logic [ID_W:0]            outstanding;
  logic                     spurious_err;

  int total = 0;
  int bad   = 0;

  int k [NUM_CH];
  int exp_ch  [16];
  int exp_tag [16];
  int exp_c;
  logic [ADDR_W-1:0] held_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_tag       (req_tag),
    .req_accept    (req_accept),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .mem_rw_out    (mem_rw_out),
    .mem_id_out    (mem_id_out),
    .mem_valid_out (mem_valid_out),
    .mem_stall_in  (mem_stall_in),
    .mem_data_in   (mem_data_in),
    .mem_id_in     (mem_id_in),
    .mem_ready_in  (mem_ready_in),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .outstanding   (outstanding),
    .spurious_err  (spurious_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int c, input int n);
    return ADDR_W'(32'h1000 * (c + 1) + 4 * n);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input int c, input int n);
    return TAG_W'((c * 8 + n) % 16);
  endfunction

  task automatic drive_read(input int c);
    req_rw[c]                   = 1'b0;
    req_addr[c*ADDR_W +: ADDR_W] = addr_of(c, k[c]);
    req_data[c*DATA_W +: DATA_W] = '0;
    req_tag[c*TAG_W +: TAG_W]    = tag_of(c, k[c]);
  endtask

  task automatic drive_write(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_rw[c]                   = 1'b1;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_data[c*DATA_W +: DATA_W] = d;
    req_tag[c*TAG_W +: TAG_W]    = '0;
  endtask

  // Safety net in case the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    req_valid    = '0;
    req_rw       = '0;
    req_addr     = '0;
    req_data     = '0;
    req_tag      = '0;
    mem_stall_in = 1'b0;
    mem_data_in  = '0;
    mem_id_in    = '0;
    mem_ready_in = 1'b0;
    for (int c = 0; c < NUM_CH; c++) k[c] = 0;

    // ---- power-on reset ----
    #1;
    check("por_valid", mem_valid_out, 0);
    check("por_outst", outstanding, 0);
    check("por_rsp", rsp_valid, 0);
    check("por_err", spurious_err, 0);
    tick();
    tick();
    reset = 1'b1;

    // ---- both channels read every cycle until all 16 IDs are taken ----
    drive_read(0);
    drive_read(1);
    req_valid = 2'b11;
    for (int i = 0; i < 16; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_c = 0;
`else
      exp_c = i % 2;
`endif
      #1;
      check($sformatf("grant%0d", i), req_accept, 64'(1) << exp_c);
      tick();
      check($sformatf("issue_v%0d", i), mem_valid_out, 1);
      check($sformatf("issue_id%0d", i), mem_id_out, i);
      check($sformatf("issue_addr%0d", i), mem_addr_out, addr_of(exp_c, k[exp_c]));
      check($sformatf("issue_rw%0d", i), mem_rw_out, 0);
      exp_ch[i]  = exp_c;
      exp_tag[i] = int'(tag_of(exp_c, k[exp_c]));
      k[exp_c]++;
      drive_read(exp_c);
    end

    // ---- full: reads refused, a write still flows with ID 0 ----
    req_valid = 2'b01;
    #1;
    check("full_rd_acc", req_accept, 0);
    check("full_outst", outstanding, 16);
    tick();
    check("full_idle", mem_valid_out, 0);
    drive_write(1, 32'h0000_3000, 32'hDEAD_BEEF);
    req_valid = 2'b11;
    #1;
    check("full_wr_acc", req_accept, 2'b10);
    tick();
    check("wr_valid", mem_valid_out, 1);
    check("wr_rw", mem_rw_out, 1);
    check("wr_id", mem_id_out, 0);
    check("wr_addr", mem_addr_out, 32'h0000_3000);
    check("wr_data", mem_data_out, 32'hDEAD_BEEF);
    check("wr_outst", outstanding, 16);

    // ---- return ID 5: routed response, ID reusable one cycle later ----
    req_valid    = 2'b01;
    mem_ready_in = 1'b1;
    mem_id_in    = 4'd5;
    mem_data_in  = 32'h1234_5678;
    #1;
    check("ret_same_cyc_acc", req_accept, 0);
    tick();
    check("ret_rsp_valid", rsp_valid, 64'(1) << exp_ch[5]);
    check("ret_rsp_tag", rsp_tag, exp_tag[5]);
    check("ret_rsp_data", rsp_data, 32'h1234_5678);
    check("ret_outst", outstanding, 15);
    check("ret_slot_idle", mem_valid_out, 0);
    mem_ready_in = 1'b0;
    #1;
    check("reuse_acc", req_accept, 2'b01);
    tick();
    check("reuse_id", mem_id_out, 5);
    check("reuse_addr", mem_addr_out, addr_of(0, k[0]));
    check("reuse_rsp_off", rsp_valid, 0);
    check("reuse_outst", outstanding, 16);
    held_addr  = addr_of(0, k[0]);
    exp_ch[5]  = 0;
    exp_tag[5] = int'(tag_of(0, k[0]));
    k[0]++;

    // ---- stall for 3 cycles: outputs held, nothing accepted ----
    drive_write(1, 32'h0000_4000, 32'hCAFE_F00D);
    req_valid    = 2'b10;
    mem_stall_in = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("stall_acc%0d", s), req_accept, 0);
      tick();
      check($sformatf("stall_v%0d", s), mem_valid_out, 1);
      check($sformatf("stall_id%0d", s), mem_id_out, 5);
      check($sformatf("stall_addr%0d", s), mem_addr_out, held_addr);
    end
    mem_stall_in = 1'b0;
    #1;
    check("unstall_acc", req_accept, 2'b10);
    tick();
    check("unstall_rw", mem_rw_out, 1);
    check("unstall_addr", mem_addr_out, 32'h0000_4000);
    check("unstall_data", mem_data_out, 32'hCAFE_F00D);
    req_valid = 2'b00;

    // ---- ID 7 returned, then returned again while free ----
    mem_ready_in = 1'b1;
    mem_id_in    = 4'd7;
    mem_data_in  = 32'h0000_0077;
    tick();
    check("id7_rsp", rsp_valid, 64'(1) << exp_ch[7]);
    check("id7_tag", rsp_tag, exp_tag[7]);
    check("id7_outst", outstanding, 15);
    check("id7_err", spurious_err, 0);
    check("id7_idle", mem_valid_out, 0);
    tick();
    check("sp_rsp", rsp_valid, 0);
    check("sp_err", spurious_err, 1);
    check("sp_outst", outstanding, 15);
    mem_ready_in = 1'b0;
    tick();
    tick();
    check("sp_sticky", spurious_err, 1);

    // ---- reset mid-traffic ----
    drive_read(0);
    drive_read(1);
    req_valid = 2'b11;
    #3;
    reset = 1'b0;
    #1;
    check("rst_valid", mem_valid_out, 0);
    check("rst_id", mem_id_out, 0);
    check("rst_addr", mem_addr_out, 0);
    check("rst_outst", outstanding, 0);
    check("rst_err", spurious_err, 0);
    check("rst_acc", req_accept, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("post_rst_acc", req_accept, 2'b01);
    tick();
    check("post_rst_id", mem_id_out, 0);
    check("post_rst_addr", mem_addr_out, addr_of(0, k[0]));
    check("post_rst_outst", outstanding, 1);
    req_valid    = 2'b00;
    mem_ready_in = 1'b1;
    mem_id_in    = 4'd3;
    tick();
    check("old_id_rsp", rsp_valid, 0);
    check("old_id_err", spurious_err, 1);
    check("old_id_outst", outstanding, 1);
    mem_ready_in = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
